// File: rtl/pio_irq_servicer_pkg.sv
// rtl/pio_irq_servicer_pkg.sv - shared types and constants for the PIO irq servicer
package pio_irq_servicer_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CFG,
    RD_EDGE,
    CLR,
    RD_DATA,
    CAP
  } state_t;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int TS_W   = 16;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/pio_irq_servicer_if.sv
// rtl/pio_irq_servicer_if.sv - Avalon-MM link between the servicer and the PIO slave
interface pio_irq_servicer_if;
  import pio_irq_servicer_pkg::*;

  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write_n;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;

  modport master (
    output m_address, m_chipselect, m_write_n, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_chipselect, m_write_n, m_writedata,
    output m_readdata
  );

endinterface

// File: rtl/pio_evt_fifo.sv
// rtl/pio_evt_fifo.sv - small synchronous event FIFO with valid/ready pop and full flag
module pio_evt_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         pop;
  logic         do_push;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = valid && ready;
  // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign do_push = push && (!full || pop);
  assign data    = mem[rd_ptr[AW-1:0]];

  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write; contents need no reset since valid gates them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pio_irq_servicer.sv
// rtl/pio_irq_servicer.sv - autonomous edge-capture PIO servicer; option PIO_IRQ_SERVICER_TSTAMP_EN adds event timestamps
module pio_irq_servicer
  import pio_irq_servicer_pkg::*;
#(
  parameter int               PIO_W     = 6,
  parameter int               DEPTH     = 4,
  parameter logic [PIO_W-1:0] MASK_INIT = 6'h3F
) (
  input  logic                clk,
  input  logic                reset_n,
  pio_irq_servicer_if.master  bus,
  input  logic                pio_irq,
  input  logic                cfg_mask_wr,
  input  logic [PIO_W-1:0]    cfg_mask,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [PIO_W-1:0]    evt_edges,
  output logic [PIO_W-1:0]    evt_level,
`ifdef PIO_IRQ_SERVICER_TSTAMP_EN
  output logic [TS_W-1:0]     evt_tstamp,
`endif
  output logic                busy
);

`ifdef PIO_IRQ_SERVICER_TSTAMP_EN
  localparam int EW = 2*PIO_W + TS_W;
`else
  localparam int EW = 2*PIO_W;
`endif

  state_t            state_q;
  state_t            state_d;
  logic              armed;
  logic              pend;
  logic [PIO_W-1:0]  pend_mask;
  logic [PIO_W-1:0]  edge_reg;
  logic              fifo_full;
  logic              push;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     pop_data;
  logic              cs;
  logic              write_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              unused_rdata;

  assign unused_rdata = ^bus.m_readdata[DATA_W-1:PIO_W];

  assign bus.m_chipselect = cs;
  assign bus.m_write_n    = write_n;
  assign bus.m_address    = addr;
  assign bus.m_writedata  = wdata;
  assign busy             = (state_q != IDLE);

  // state register plus the one-shot arm flag that keeps the bus quiet during reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      armed   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed   <= 1'b1;
    end
  end

  // next state and bus outputs for the fixed service sequence
  always_comb begin
    state_d = state_q;
    cs      = 1'b0;
    write_n = 1'b1;
    addr    = ADDR_DATA;
    wdata   = '0;
    case (state_q)
      INIT: begin
        if (armed) begin
          cs      = 1'b1;
          write_n = 1'b0;
          addr    = ADDR_MASK;
          wdata   = {{(DATA_W-PIO_W){1'b0}}, MASK_INIT};
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (pend)                       state_d = CFG;
        else if (pio_irq && !fifo_full) state_d = RD_EDGE;
      end
      CFG: begin
        cs      = 1'b1;
        write_n = 1'b0;
        addr    = ADDR_MASK;
        wdata   = {{(DATA_W-PIO_W){1'b0}}, pend_mask};
        state_d = IDLE;
      end
      RD_EDGE: begin
        cs      = 1'b1;
        addr    = ADDR_EDGE;
        state_d = CLR;
      end
      CLR: begin
        cs      = 1'b1;
        write_n = 1'b0;
        addr    = ADDR_EDGE;
        wdata   = '1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        cs      = 1'b1;
        addr    = ADDR_DATA;
        state_d = CAP;
      end
      CAP: begin
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // pending mask request; a pulse during CFG re-arms it for another pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend      <= 1'b0;
      pend_mask <= '0;
    end else if (cfg_mask_wr) begin
      pend      <= 1'b1;
      pend_mask <= cfg_mask;
    end else if (state_q == CFG) begin
      pend      <= 1'b0;
    end
  end

  // edge_capture read data arrives during CLR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             edge_reg <= '0;
    else if (state_q == CLR)  edge_reg <= bus.m_readdata[PIO_W-1:0];
  end

  // level read data arrives during CAP and goes straight into the event
  assign push = (state_q == CAP) && (edge_reg != '0);

`ifdef PIO_IRQ_SERVICER_TSTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_reg;

  // free-running timestamp, sampled when the edge register is read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      ts_reg <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (state_q == RD_EDGE) ts_reg <= ts_cnt;
    end
  end

  assign push_data = {ts_reg, edge_reg, bus.m_readdata[PIO_W-1:0]};
  assign {evt_tstamp, evt_edges, evt_level} = pop_data;
`else
  assign push_data = {edge_reg, bus.m_readdata[PIO_W-1:0]};
  assign {evt_edges, evt_level} = pop_data;
`endif

  pio_evt_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .valid     (evt_valid),
    .ready     (evt_ready),
    .data      (pop_data)
  );

endmodule
